// File: rtl/ifu_fetch_pkg.sv
// ============================================================================
// ifu_fetch_pkg : shared decode opcodes and fetch FSM state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package ifu_fetch_pkg;

  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_BRANCH = 5'b11000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_REQ  = 2'd1,
    WAIT_RESP = 2'd2
  } ifu_state_t;

endpackage

`default_nettype wire

// File: rtl/ifu_queue.sv
// ============================================================================
// ifu_queue : synchronous FIFO of {pc, inst} entries between imem and decode
// Rev 1.0
// ============================================================================
`default_nettype none

module ifu_queue #(
  parameter int QDEPTH = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      push,
  input  logic [63:0]               push_data,
  input  logic                      pop,
  input  logic                      clear,
  output logic [63:0]               head,
  output logic [$clog2(QDEPTH):0]   count,
  output logic                      empty,
  output logic                      full
);

  localparam int AW = $clog2(QDEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(QDEPTH);

  logic [63:0]   mem [QDEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < QDEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

`default_nettype wire

// File: rtl/ifu_fetch.sv
// ============================================================================
// ifu_fetch : fetch PC, single-outstanding imem requests, static prediction
// Rev 1.0
// ============================================================================
`default_nettype none

module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h3000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] flush_dnpc,
  input  logic        jump_flush,
  input  logic [31:0] jump_dnpc,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] QDEPTH_CNT = CW'(QDEPTH);

  ifu_state_t    state;
  logic [31:0]   pc;
  logic [31:0]   addr_q;
  logic          drop;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic [63:0]   head;
  logic          redir;
  logic [31:0]   target;
  logic          issue;
  logic          push;
  logic [31:0]   imm_j;
  logic [31:0]   imm_b;
  logic [31:0]   next_pc;

  assign redir  = flush | jump_flush;
  assign target = flush ? flush_dnpc : jump_dnpc;

  // Gated by reset so no request is visible while the block is held in reset.
  assign issue     = reset & (state == IDLE) & ~full & (count < QDEPTH_CNT) & ~redir;
  assign req_valid = issue | (state == WAIT_REQ);
  assign req_addr  = (state == IDLE) ? {pc[31:2], 2'b00} : addr_q;

  assign push      = (state == WAIT_RESP) & resp_valid & ~drop;
  assign out_valid = ~empty & ~flush & ~jump_flush;
  assign out_pc    = head[63:32];
  assign out_inst  = head[31:0];

  always_comb begin
    imm_j   = {{12{resp_data[31]}}, resp_data[19:12], resp_data[20], resp_data[30:21], 1'b0};
    imm_b   = {{20{resp_data[31]}}, resp_data[7], resp_data[30:25], resp_data[11:8], 1'b0};
    next_pc = pc + 32'd4;
    if (resp_data[6:2] == OP_JAL)
      next_pc = pc + imm_j;
    else if (resp_data[6:2] == OP_BRANCH && resp_data[31])
      next_pc = pc + imm_b;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      addr_q <= RESET_PC;
      drop   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            addr_q <= {pc[31:2], 2'b00};
            state  <= req_ready ? WAIT_RESP : WAIT_REQ;
          end
        end
        WAIT_REQ: begin
          if (req_ready) state <= WAIT_RESP;
          if (redir)     drop  <= 1'b1;
        end
        WAIT_RESP: begin
          if (resp_valid) begin
            drop  <= 1'b0;
            state <= IDLE;
            if (!drop && !redir) pc <= next_pc;
          end else if (redir) begin
            drop <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      // A redirect overrides any prediction update from this cycle.
      if (redir) pc <= target;
    end
  end

  ifu_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data ({pc, resp_data}),
    .pop       (out_valid & out_ready),
    .clear     (redir),
    .head      (head),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

endmodule

`default_nettype wire
